rob_ctrl: RTL

- Reorder-buffer controller for the out-of-order core.
- Allocates ROB tags at issue and collects results from the ALU and LSB writeback buses.
- Retires at most one entry per cycle in program order, driving the register file's commit port (commit/commit_rd/commit_val/commit_rob_pos) and releasing stores to the LSB.
- Detects branch mispredicts at the head and sequences the global rollback that the register file and all other units consume.

---
 rtl/rob_ctrl_pkg.sv | 26 ++
 rtl/rob_entry_mem.sv | 104 ++++++++++
 rtl/rob_ctrl.sv | 132 +++++++++++++
 3 files changed

// File: rtl/rob_ctrl_pkg.sv
// Shared reorder-buffer types and sizes.
// Entry record, issue type encodings, width constants.
package rob_ctrl_pkg;
  localparam int ROB_SIZE = 16;
  localparam int ROB_W = 4;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    TYPE_REG = 2'd0,
    TYPE_BR  = 2'd1,
    TYPE_ST  = 2'd2
  } rob_type_e;

  typedef struct packed {
    logic              valid;
    logic              ready;
    rob_type_e         typ;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] pc;
    logic              pred_taken;
    logic [DATA_W-1:0] val;
    logic              taken;
    logic [DATA_W-1:0] target;
  } rob_entry_t;
endpackage

// File: rtl/rob_entry_mem.sv
// ROB entry array: issue + writeback write ports, head read,
// two operand query ports with same-cycle writeback forwarding.
module rob_entry_mem
  import rob_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              flush,
  input  logic              iss_we,
  input  logic [ROB_W-1:0]  iss_pos,
  input  logic [1:0]        iss_type,
  input  logic [REG_W-1:0]  iss_rd,
  input  logic [DATA_W-1:0] iss_pc,
  input  logic              iss_pred,
  input  logic              alu_wb,
  input  logic [ROB_W-1:0]  alu_pos,
  input  logic [DATA_W-1:0] alu_val,
  input  logic              alu_taken,
  input  logic [DATA_W-1:0] alu_target,
  input  logic              lsb_wb,
  input  logic [ROB_W-1:0]  lsb_pos,
  input  logic [DATA_W-1:0] lsb_val,
  input  logic              ret_clr,
  input  logic [ROB_W-1:0]  head,
  output rob_entry_t        head_ent,
  input  logic [ROB_W-1:0]  q1_pos,
  output logic              q1_rdy,
  output logic [DATA_W-1:0] q1_val,
  input  logic [ROB_W-1:0]  q2_pos,
  output logic              q2_rdy,
  output logic [DATA_W-1:0] q2_val
);
  rob_entry_t ents [ROB_SIZE];

  assign head_ent = ents[head];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        ents[i].valid <= 1'b0;
        ents[i].ready <= 1'b0;
      end
    end else if (en) begin
      if (flush) begin
        for (int i = 0; i < ROB_SIZE; i++) begin
          ents[i].valid <= 1'b0;
          ents[i].ready <= 1'b0;
        end
      end else begin
        if (iss_we) begin
          ents[iss_pos] <= '{
            valid: 1'b1, ready: 1'b0,
            typ: rob_type_e'(iss_type),
            rd: iss_rd, pc: iss_pc,
            pred_taken: iss_pred,
            val: '0, taken: 1'b0,
            target: '0};
        end
        if (alu_wb && ents[alu_pos].valid) begin
          ents[alu_pos].ready  <= 1'b1;
          ents[alu_pos].val    <= alu_val;
          ents[alu_pos].taken  <= alu_taken;
          ents[alu_pos].target <= alu_target;
        end
        if (lsb_wb && ents[lsb_pos].valid) begin
          ents[lsb_pos].ready <= 1'b1;
          ents[lsb_pos].val   <= lsb_val;
        end
        // retire last so a stale writeback cannot revive the head
        if (ret_clr) begin
          ents[head].valid <= 1'b0;
          ents[head].ready <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    q1_rdy = ents[q1_pos].ready;
    q1_val = ents[q1_pos].val;
    if (lsb_wb && lsb_pos == q1_pos) begin
      q1_rdy = 1'b1;
      q1_val = lsb_val;
    end
    if (alu_wb && alu_pos == q1_pos) begin
      q1_rdy = 1'b1;
      q1_val = alu_val;
    end
  end

  always_comb begin
    q2_rdy = ents[q2_pos].ready;
    q2_val = ents[q2_pos].val;
    if (lsb_wb && lsb_pos == q2_pos) begin
      q2_rdy = 1'b1;
      q2_val = lsb_val;
    end
    if (alu_wb && alu_pos == q2_pos) begin
      q2_rdy = 1'b1;
      q2_val = alu_val;
    end
  end
endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: tag allocation, in-order retire,
// commit/store release, mispredict rollback. Ports: issue, wb, query, commit.
module rob_ctrl
  import rob_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              issue,
  input  logic [1:0]        issue_type,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic [DATA_W-1:0] issue_pc,
  input  logic              issue_pred_taken,
  output logic [ROB_W-1:0]  issue_rob_pos,
  output logic              full,
  input  logic              alu_wb,
  input  logic [ROB_W-1:0]  alu_wb_pos,
  input  logic [DATA_W-1:0] alu_wb_val,
  input  logic              alu_wb_taken,
  input  logic [DATA_W-1:0] alu_wb_target,
  input  logic              lsb_wb,
  input  logic [ROB_W-1:0]  lsb_wb_pos,
  input  logic [DATA_W-1:0] lsb_wb_val,
  input  logic [ROB_W-1:0]  q1_pos,
  output logic              q1_rdy,
  output logic [DATA_W-1:0] q1_val,
  input  logic [ROB_W-1:0]  q2_pos,
  output logic              q2_rdy,
  output logic [DATA_W-1:0] q2_val,
  output logic              commit,
  output logic [REG_W-1:0]  commit_rd,
  output logic [DATA_W-1:0] commit_val,
  output logic [ROB_W-1:0]  commit_rob_pos,
  output logic              store_commit,
  output logic [ROB_W-1:0]  store_rob_pos,
  output logic              rollback,
  output logic [DATA_W-1:0] rollback_pc
);
  localparam logic [ROB_W:0] CNT_FULL = (ROB_W+1)'(ROB_SIZE);

  logic [ROB_W-1:0] head;
  logic [ROB_W-1:0] tail;
  logic [ROB_W:0]   count;
  rob_entry_t       h;
  logic             accept;
  logic             retire;
  logic             mispred;

  assign full          = count == CNT_FULL;
  assign issue_rob_pos = tail;
  assign accept        = issue && !full;
  assign retire        = h.valid && h.ready;
  assign mispred       = retire && h.typ == TYPE_BR &&
                         h.taken != h.pred_taken;

  rob_entry_mem u_mem (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (rdy),
    .flush      (mispred),
    .iss_we     (accept),
    .iss_pos    (tail),
    .iss_type   (issue_type),
    .iss_rd     (issue_rd),
    .iss_pc     (issue_pc),
    .iss_pred   (issue_pred_taken),
    .alu_wb     (alu_wb),
    .alu_pos    (alu_wb_pos),
    .alu_val    (alu_wb_val),
    .alu_taken  (alu_wb_taken),
    .alu_target (alu_wb_target),
    .lsb_wb     (lsb_wb),
    .lsb_pos    (lsb_wb_pos),
    .lsb_val    (lsb_wb_val),
    .ret_clr    (retire),
    .head       (head),
    .head_ent   (h),
    .q1_pos     (q1_pos),
    .q1_rdy     (q1_rdy),
    .q1_val     (q1_val),
    .q2_pos     (q2_pos),
    .q2_rdy     (q2_rdy),
    .q2_val     (q2_val)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      commit         <= 1'b0;
      commit_rd      <= '0;
      commit_val     <= '0;
      commit_rob_pos <= '0;
      store_commit   <= 1'b0;
      store_rob_pos  <= '0;
      rollback       <= 1'b0;
      rollback_pc    <= '0;
    end else if (!rdy) begin
      commit       <= 1'b0;
      store_commit <= 1'b0;
      rollback     <= 1'b0;
    end else begin
      commit       <= 1'b0;
      store_commit <= 1'b0;
      rollback     <= 1'b0;
      if (retire) begin
        if (h.typ == TYPE_ST) begin
          store_commit  <= 1'b1;
          store_rob_pos <= head;
        end else if (h.rd != '0) begin
          // branches with a link register commit it here too
          commit         <= 1'b1;
          commit_rd      <= h.rd;
          commit_val     <= h.val;
          commit_rob_pos <= head;
        end
      end
      if (mispred) begin
        rollback    <= 1'b1;
        rollback_pc <= h.taken ? h.target : h.pc + DATA_W'(4);
        head        <= '0;
        tail        <= '0;
        count       <= '0;
      end else begin
        head  <= head + ROB_W'(retire);
        tail  <= tail + ROB_W'(accept);
        count <= count + (ROB_W+1)'(accept) - (ROB_W+1)'(retire);
      end
    end
  end
endmodule
